// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: glyph table, blank pattern and scan FSM states.
// Used by both the hex-to-segment encoder and the display bus reader.
package seg7_pkg;

  // Segment lines are active-low (0 lights a segment), bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HELD} scan_state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    return SEG_0;
      4'h1:    return SEG_1;
      4'h2:    return SEG_2;
      4'h3:    return SEG_3;
      4'h4:    return SEG_4;
      4'h5:    return SEG_5;
      4'h6:    return SEG_6;
      4'h7:    return SEG_7;
      4'h8:    return SEG_8;
      4'h9:    return SEG_9;
      4'hA:    return SEG_A;
      4'hB:    return SEG_B;
      4'hC:    return SEG_C;
      4'hD:    return SEG_D;
      4'hE:    return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational inverse of the glyph table: segment pattern -> hex nibble,
// plus flags for a recognised glyph and for an all-dark (blank) digit.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nib,
  output logic       o_is_glyph,
  output logic       o_is_blank
);

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    o_nib      = '0;
    o_is_glyph = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i_seg == hex_to_seg(4'(i))) begin
        o_nib      = 4'(i);
        o_is_glyph = 1'b1;
      end
    end
  end

  assign o_is_blank = (i_seg == SEG_BLANK);

endmodule

// File: rtl/seg7_scan_capture.sv
// Monitors a multiplexed 7-segment scan bus and rebuilds the nibble shown on
// each digit once its pattern has dwelt for STABLE_CYC consecutive samples.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter  int DIGITS     = 6,
  parameter  int STABLE_CYC = 4,
  localparam int CNT_W      = $clog2(STABLE_CYC + 1),
  localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     sel,
  output logic [4*DIGITS-1:0]   digit_data,
  output logic [DIGITS-1:0]     digit_vld,
  output logic                  cap_pulse,
  output logic [IDX_W-1:0]      cap_idx,
  output logic                  bad_pat,
  output logic                  bad_sel,
  output logic                  frame_done
);

  localparam logic [DIGITS-1:0] SEL_NONE = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYC);

  logic [6:0]        r_seg;
  logic [DIGITS-1:0] r_sel;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  scan_state_e       r_state;
  scan_state_e       w_state_nxt;
  logic [DIGITS-1:0] r_frame_mask;
  logic [3:0]        w_nib;
  logic              w_is_glyph;
  logic              w_is_blank;
  logic              w_enter_held;
  logic              w_sel_onehot;
  logic [IDX_W-1:0]  w_idx;

  seg7_glyph_decode u_decode (
    .i_seg      (r_seg),
    .o_nib      (w_nib),
    .o_is_glyph (w_is_glyph),
    .o_is_blank (w_is_blank)
  );

  // The counter tracks how long the value about to sit in r_seg/r_sel has been seen.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (sel == SEL_NONE) begin
      w_cnt_nxt = '0;
    end else if ({seg, sel} != {r_seg, r_sel}) begin
      w_cnt_nxt = CNT_W'(1);
    end else if (r_cnt != CNT_MAX) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = ST_SETTLE;
    if (r_sel == SEL_NONE) begin
      w_state_nxt = ST_IDLE;
    end else if (r_cnt == CNT_MAX) begin
      w_state_nxt = ST_HELD;
    end
  end

  assign w_enter_held = (w_state_nxt == ST_HELD) && (r_state != ST_HELD);
  assign w_sel_onehot = ($countones(~r_sel) == 1);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!r_sel[i]) w_idx = IDX_W'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg        <= SEG_BLANK;
      r_sel        <= SEL_NONE;
      r_cnt        <= '0;
      r_state      <= ST_IDLE;
      r_frame_mask <= '0;
      // NOTE: the digit store is a handful of flops, not a RAM, so it is
      // cleared by reset along with everything else.
      digit_data   <= '0;
      digit_vld    <= '0;
      cap_pulse    <= 1'b0;
      cap_idx      <= '0;
      bad_pat      <= 1'b0;
      bad_sel      <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      r_seg      <= seg;
      r_sel      <= sel;
      r_cnt      <= w_cnt_nxt;
      r_state    <= w_state_nxt;
      cap_pulse  <= 1'b0;
      bad_pat    <= 1'b0;
      bad_sel    <= 1'b0;
      frame_done <= 1'b0;
      if (w_enter_held) begin
        if (!w_sel_onehot) begin
          bad_sel <= 1'b1;
        end else if (w_is_glyph || w_is_blank) begin
          cap_pulse <= 1'b1;
          cap_idx   <= w_idx;
          if (w_is_glyph) begin
            digit_data[4*w_idx +: 4] <= w_nib;
            digit_vld[w_idx]         <= 1'b1;
          end else begin
            digit_vld[w_idx] <= 1'b0;
          end
          // Completing the mask closes the frame and starts the next one empty.
          if ((r_frame_mask | ~r_sel) == '1) begin
            frame_done   <= 1'b1;
            r_frame_mask <= '0;
          end else begin
            r_frame_mask <= r_frame_mask | ~r_sel;
          end
        end else begin
          bad_pat <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Reader for the multiplexed 7-segment display bus: takes the active-low segment lines and the active-low digit-select lines that drive the board display, and rebuilds the hex nibble shown on each digit.
- Used as an on-chip display monitor for self-check and loopback benches, and to expose the displayed value to other logic.
- Sits beside the scan driver and samples the same wires it drives.

Parameters:
- DIGITS, 6, number of display digits / width of sel.
- STABLE_CYC, 4, consecutive identical samples needed before a digit is captured (min 2).
- CNT_W, $clog2(STABLE_CYC+1), localparam, dwell counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- seg  in  7  segment lines, active-low, bit order {g,f,e,d,c,b,a}. Synchronous to clk.
- sel  in  DIGITS  digit select, active-low, one-hot-low when valid. Synchronous to clk.
- digit_data  out  4*DIGITS  captured nibble per digit; digit i is at [4i+3:4i].
- digit_vld  out  DIGITS  digit i holds a valid hex value.
- cap_pulse  out  1  one-cycle strobe on every capture.
- cap_idx  out  $clog2(DIGITS)  index of the digit captured with cap_pulse.
- bad_pat  out  1  one-cycle strobe: a stable pattern matched neither a glyph nor blank.
- bad_sel  out  1  one-cycle strobe: a stable sel had more than one bit low.
- frame_done  out  1  one-cycle strobe: every digit has captured since the last frame_done.

Behaviour:
- Glyph table (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Blank=1111111.
- Input stage: seg and sel are registered once (r_seg, r_sel). There is no synchroniser.
- Dwell counter cnt:
  - Loads 1 when {r_seg, r_sel} differs from its previous registered value.
  - Otherwise increments, saturating at STABLE_CYC.
- State machine:
  - IDLE: r_sel all ones, no digit selected. cnt is held at 0.
  - SETTLE: a digit is selected and cnt < STABLE_CYC.
  - HELD: cnt == STABLE_CYC. The capture fires once, on entry.
  - Any change of r_seg or r_sel returns the machine to SETTLE (or to IDLE if r_sel is all ones).
- Capture action on entry to HELD, with r_sel one-hot-low:
  - Glyph match: digit_data[idx] is set to the nibble and digit_vld[idx] to 1. cap_pulse=1, cap_idx=idx.
  - Blank: digit_vld[idx] is set to 0 and digit_data[idx] is held. cap_pulse=1, cap_idx=idx.
  - No match: bad_pat=1. digit_data and digit_vld are unchanged, cap_pulse=0.
- On entry to HELD with more than one sel bit low: bad_sel=1 and nothing else changes.
- Latency: if the inputs change before edge e0 and then hold, cap_pulse and the updated digit_data are visible after edge e0+STABLE_CYC. Total latency is STABLE_CYC+1 clocks from the input change.
- A dwell shorter than STABLE_CYC samples captures nothing (glitch/ghosting rejection).
- A dwell longer than STABLE_CYC captures exactly once, with no repeat until the inputs change.
- frame_mask (DIGITS bits):
  - Bit idx is set on each cap_pulse, whether glyph or blank.
  - When the mask with the current capture included becomes all ones, frame_done pulses in the same cycle as that cap_pulse, and the mask clears to 0 on the same edge.
- A repeated capture of the same digit before the frame completes is legal. It overwrites the data and does not advance the mask.
- Reset: asynchronous and immediate, also mid-dwell. Every register clears:
  - digit_data=0, digit_vld=0, frame_mask=0, cnt=0, state=IDLE.
  - cap_pulse, bad_pat, bad_sel, frame_done are 0; cap_idx=0.
  - r_seg=7'h7F, r_sel=all ones.
- All strobes are single-cycle registered outputs and are mutually exclusive per cycle, except that cap_pulse and frame_done coincide.

Decomposition:
- Shared package seg7_pkg:
  - The 16 glyph constants, SEG_BLANK=7'h7F, and the segment bit-order definition.
  - The existing hex-to-segment encoder also uses this package, so both ends share one table.
- Sub-module seg7_glyph_decode: combinational; seg[6:0] -> {nib[3:0], is_glyph, is_blank}.
- This module holds the input registers, the dwell counter/FSM, the per-digit storage, and the frame tracking.

Test Plan (STABLE_CYC=4, DIGITS=6):
- Reset, then sel=6'b111110, seg=0100100 held 6 cycles -> one cap_pulse, cap_idx=0, digit_data[3:0]=2, digit_vld=000001, arriving 5 clocks after the change.
- sel=6'b111101, seg=0001000 held 3 cycles, then changed -> no cap_pulse, digit_vld unchanged. Held 4 cycles instead -> digit 1 = A.
- Scan digits 0..5 with 1,2,3,4,5,F, each for 5 cycles -> six cap_pulses, then frame_done with the 6th; digit_data=24'hF54321, digit_vld=6'h3F.
- seg=1010101 on digit 2 held 5 cycles -> bad_pat pulse, no cap_pulse, digit 2 unchanged. Repeat with sel=6'b111100 -> bad_sel pulse only.
- After a full frame, blank (1111111) on digit 3 for 5 cycles -> cap_pulse with cap_idx=3, digit_vld=6'b110111, digit_data unchanged.
- Deassert rst_n mid-dwell (cnt=2) -> all outputs 0 immediately. After release, the same held pattern needs a full STABLE_CYC+1 clocks before it captures.
